// File: rtl/alu_res_packer_if.sv
// alu_res_packer_if: ALU result part stream in, vector register write out
interface alu_res_packer_if #(
    parameter int PIPE_W = 32,
    parameter int VREG_W = 128
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [PIPE_W-1:0]     in_res_i;
    logic [PIPE_W/8-1:0]   in_mask_i;
    logic                  in_first_i;
    logic                  in_last_i;
    logic [4:0]            in_vaddr_i;
    logic                  wr_valid_o;
    logic                  wr_ready_i;
    logic [4:0]            wr_addr_o;
    logic [VREG_W-1:0]     wr_data_o;
    logic [VREG_W/8-1:0]   wr_be_o;

    modport master (
        output in_valid_i, in_res_i, in_mask_i, in_first_i, in_last_i, in_vaddr_i, wr_ready_i,
        input  in_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_be_o
    );
    modport slave (
        input  in_valid_i, in_res_i, in_mask_i, in_first_i, in_last_i, in_vaddr_i, wr_ready_i,
        output in_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_be_o
    );
endinterface

// File: rtl/alu_res_packer.sv
// alu_res_packer: packs PIPE_W-wide ALU result parts into one VREG_W register write
module alu_res_packer #(
    parameter int PIPE_W = 32,
    parameter int VREG_W = 128
) (
    input logic              clk_i,
    input logic              async_rst_ni,
    alu_res_packer_if.slave  bus
);
    localparam int N  = VREG_W / PIPE_W;
    localparam int CW = $clog2(N);
    localparam int BW = PIPE_W / 8;

    typedef enum logic {FILL, FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, slice;
    logic [4:0]               addr_q;
    logic [N-1:0][PIPE_W-1:0] data_q;
    logic [N-1:0][BW-1:0]     be_q;
    logic                     last_q, in_acc, wr_acc, part_end;

    assign bus.in_ready_o = state_q == FILL;
    assign bus.wr_valid_o = state_q == FLUSH;
    assign bus.wr_addr_o  = addr_q;
    assign bus.wr_data_o  = data_q;
    assign bus.wr_be_o    = be_q;

    assign in_acc   = bus.in_valid_i && bus.in_ready_o;
    assign wr_acc   = bus.wr_valid_o && bus.wr_ready_i;
    // a first part restarts the register, discarding any buffered partial parts
    assign slice    = bus.in_first_i ? '0 : cnt_q;
    assign part_end = (&slice) || bus.in_last_i;

    always_comb begin
        state_d = state_q;
        if (in_acc && part_end) state_d = FLUSH;
        else if (wr_acc) state_d = FILL;
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) state_q <= FILL;
        else state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            cnt_q  <= '0;
            addr_q <= '0;
            be_q   <= '0;
            last_q <= 1'b0;
        end else if (wr_acc) begin
            cnt_q  <= '0;
            be_q   <= '0;
            // streams spanning several registers advance to the next one
            addr_q <= last_q ? addr_q : addr_q + 5'd1;
        end else if (in_acc) begin
            if (bus.in_first_i) begin
                be_q   <= '0;
                addr_q <= bus.in_vaddr_i;
            end
            be_q[slice] <= bus.in_mask_i;
            cnt_q       <= slice + CW'(1);
            last_q      <= bus.in_last_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_acc) data_q[slice] <= bus.in_res_i;
    end
endmodule

// File: tb/tb_alu_res_packer.sv
// tb_alu_res_packer: directed checks of part packing, flush stalls, address wrap and reset
module tb_alu_res_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    alu_res_packer_if #(.PIPE_W(32), .VREG_W(128)) bus ();

    alu_res_packer #(.PIPE_W(32), .VREG_W(128)) dut (
        .clk_i(clk),
        .async_rst_ni(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] res, input logic [3:0] mask, input logic first,
                       input logic last, input logic [4:0] vaddr);
        int n = 0;
        bus.in_valid_i = 1'b1;
        bus.in_res_i   = res;
        bus.in_mask_i  = mask;
        bus.in_first_i = first;
        bus.in_last_i  = last;
        bus.in_vaddr_i = vaddr;
        while (!bus.in_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("put_timeout", 128'(n), 128'(0));
        tick();
        bus.in_valid_i = 1'b0;
        bus.in_first_i = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    initial begin
        bus.in_valid_i = 1'b0;
        bus.in_res_i   = '0;
        bus.in_mask_i  = '0;
        bus.in_first_i = 1'b0;
        bus.in_last_i  = 1'b0;
        bus.in_vaddr_i = '0;
        bus.wr_ready_i = 1'b0;
        #2;
        chk("rst_in_ready", 128'(bus.in_ready_o), 128'(1));
        chk("rst_wr_valid", 128'(bus.wr_valid_o), 128'(0));
        #10 rst_n = 1'b1;
        tick();
        // four full parts into register 5
        bus.wr_ready_i = 1'b1;
        put(32'h11111111, 4'hF, 1'b1, 1'b0, 5'd5);
        put(32'h22222222, 4'hF, 1'b0, 1'b0, 5'd0);
        put(32'h33333333, 4'hF, 1'b0, 1'b0, 5'd0);
        chk("t1_no_early_wr", 128'(bus.wr_valid_o), 128'(0));
        put(32'h44444444, 4'hF, 1'b0, 1'b1, 5'd0);
        chk("t1_wr_valid", 128'(bus.wr_valid_o), 128'(1));
        chk("t1_in_ready_low", 128'(bus.in_ready_o), 128'(0));
        chk("t1_addr", 128'(bus.wr_addr_o), 128'(5));
        chk("t1_data", bus.wr_data_o, 128'h44444444_33333333_22222222_11111111);
        chk("t1_be", 128'(bus.wr_be_o), 128'hFFFF);
        tick();
        chk("t1_wr_done", 128'(bus.wr_valid_o), 128'(0));
        chk("t1_in_ready_back", 128'(bus.in_ready_o), 128'(1));
        // eight parts from register 31 wrap to register 0
        for (int i = 0; i < 8; i++) begin
            put(32'h10000000 + 32'(i), 4'hF, i == 0, i == 7, 5'd31);
            if (i == 3) begin
                chk("t2_wr1_valid", 128'(bus.wr_valid_o), 128'(1));
                chk("t2_wr1_addr", 128'(bus.wr_addr_o), 128'(31));
                chk("t2_wr1_data", bus.wr_data_o, 128'h10000003_10000002_10000001_10000000);
                chk("t2_wr1_be", 128'(bus.wr_be_o), 128'hFFFF);
            end
        end
        chk("t2_wr2_valid", 128'(bus.wr_valid_o), 128'(1));
        chk("t2_wr2_addr", 128'(bus.wr_addr_o), 128'(0));
        chk("t2_wr2_data", bus.wr_data_o, 128'h10000007_10000006_10000005_10000004);
        chk("t2_wr2_be", 128'(bus.wr_be_o), 128'hFFFF);
        tick();
        // partial register with byte masks
        put(32'hAAAA0003, 4'h3, 1'b1, 1'b0, 5'd2);
        put(32'hBBBB000F, 4'hF, 1'b0, 1'b1, 5'd0);
        chk("t3_addr", 128'(bus.wr_addr_o), 128'(2));
        chk("t3_be", 128'(bus.wr_be_o), 128'h00F3);
        chk("t3_data_lo", 128'(bus.wr_data_o[63:0]), 128'hBBBB000F_AAAA0003);
        tick();
        // flush stalled by register file while the next part waits
        bus.wr_ready_i = 1'b0;
        put(32'hC1C1C1C1, 4'hF, 1'b1, 1'b0, 5'd10);
        put(32'hC2C2C2C2, 4'hF, 1'b0, 1'b0, 5'd0);
        put(32'hC3C3C3C3, 4'hF, 1'b0, 1'b0, 5'd0);
        put(32'hC4C4C4C4, 4'hF, 1'b0, 1'b0, 5'd0);
        bus.in_valid_i = 1'b1;
        bus.in_res_i   = 32'hDDDDDDDD;
        bus.in_mask_i  = 4'hF;
        bus.in_last_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_stall_valid", 128'(bus.wr_valid_o), 128'(1));
            chk("t4_stall_ready", 128'(bus.in_ready_o), 128'(0));
            chk("t4_stall_data", bus.wr_data_o, 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1);
            chk("t4_stall_addr", 128'(bus.wr_addr_o), 128'(10));
        end
        bus.wr_ready_i = 1'b1;
        tick();
        chk("t4_accept_ready", 128'(bus.in_ready_o), 128'(1));
        tick();
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        chk("t4_next_valid", 128'(bus.wr_valid_o), 128'(1));
        chk("t4_next_addr", 128'(bus.wr_addr_o), 128'(11));
        chk("t4_next_be", 128'(bus.wr_be_o), 128'h000F);
        chk("t4_next_data", 128'(bus.wr_data_o[31:0]), 128'hDDDDDDDD);
        tick();
        // new first discards two buffered parts
        put(32'hE1E1E1E1, 4'hF, 1'b1, 1'b0, 5'd3);
        put(32'hE2E2E2E2, 4'hF, 1'b0, 1'b0, 5'd0);
        chk("t5_no_wr", 128'(bus.wr_valid_o), 128'(0));
        put(32'hF1F1F1F1, 4'hF, 1'b1, 1'b0, 5'd9);
        chk("t5_no_wr2", 128'(bus.wr_valid_o), 128'(0));
        put(32'hF2F2F2F2, 4'hF, 1'b0, 1'b1, 5'd0);
        chk("t5_addr", 128'(bus.wr_addr_o), 128'(9));
        chk("t5_be", 128'(bus.wr_be_o), 128'h00FF);
        chk("t5_data_lo", 128'(bus.wr_data_o[63:0]), 128'hF2F2F2F2_F1F1F1F1);
        tick();
        // single part then asynchronous reset mid-flush
        bus.wr_ready_i = 1'b0;
        put(32'h0000005A, 4'h1, 1'b1, 1'b1, 5'd7);
        chk("t6_valid", 128'(bus.wr_valid_o), 128'(1));
        chk("t6_addr", 128'(bus.wr_addr_o), 128'(7));
        chk("t6_be", 128'(bus.wr_be_o), 128'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_valid", 128'(bus.wr_valid_o), 128'(0));
        chk("t6_rst_in_ready", 128'(bus.in_ready_o), 128'(1));
        chk("t6_rst_be", 128'(bus.wr_be_o), 128'h0000);
        #3 rst_n = 1'b1;
        bus.wr_ready_i = 1'b1;
        tick();
        put(32'h77777777, 4'hF, 1'b0, 1'b1, 5'd0);
        chk("t6_post_addr", 128'(bus.wr_addr_o), 128'(0));
        chk("t6_post_be", 128'(bus.wr_be_o), 128'h000F);
        chk("t6_post_data", 128'(bus.wr_data_o[31:0]), 128'h77777777);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_res_packer.md
ALU_RES_PACKER -- requirements
Module: alu_res_packer

Interface
REQ-001 SHALL have parameter PIPE_W, default 32: width of one ALU result part in bits; multiple of 8.
REQ-002 SHALL have parameter VREG_W, default 128: vector register width in bits; VREG_W/PIPE_W (=N) a power of two, N>=2.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port async_rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid_i, input, 1: ALU result part valid.
REQ-006 SHALL have port in_ready_o, output, 1: packer accepts part.
REQ-007 SHALL have port in_res_i, input, PIPE_W: ALU result part.
REQ-008 SHALL have port in_mask_i, input, PIPE_W/8: per-byte write mask of the part.
REQ-009 SHALL have port in_first_i, input, 1: part starts a new instruction.
REQ-010 SHALL have port in_last_i, input, 1: part ends the instruction.
REQ-011 SHALL have port in_vaddr_i, input, 5: destination register; sampled only with in_first_i.
REQ-012 SHALL have port wr_valid_o, output, 1: register write request.
REQ-013 SHALL have port wr_ready_i, input, 1: register file accepts write.
REQ-014 SHALL have port wr_addr_o, output, 5: destination register.
REQ-015 SHALL have port wr_data_o, output, VREG_W: packed register data.
REQ-016 SHALL have port wr_be_o, output, VREG_W/8: per-byte write enables.

Function
REQ-017 SHALL implement two states: FILL and FLUSH; in_ready_o = (state==FILL); wr_valid_o = (state==FLUSH).
REQ-018 Part accepted when in_valid_i && in_ready_o; write accepted when wr_valid_o && wr_ready_i.
REQ-019 In FILL, accepted part SHALL be written to slice cnt of data buffer (bits cnt*PIPE_W upward) and in_mask_i to slice cnt of byte-enable buffer; cnt is a log2(N)-bit part counter.
REQ-020 Accepted part with in_first_i=1 SHALL go to slice 0 regardless of cnt, clear byte enables of all other slices, load addr from in_vaddr_i.
REQ-021 After accepted part: if slice index==N-1 or in_last_i=1, SHALL enter FLUSH; else cnt SHALL increment by 1.
REQ-022 In FLUSH, wr_data_o/wr_be_o/wr_addr_o SHALL hold stable until write accepted; unwritten slices carry be=0.
REQ-023 On write accept: SHALL return to FILL, cnt=0, clear all byte enables; addr SHALL increment by 1 modulo 32 (31 wraps to 0) unless the flushed register ended with in_last_i, then addr unchanged.
REQ-024 Throughput: one register per N+1 cycles with wr_ready_i=1; write appears cycle after last part accepted (latency 1).
REQ-025 in_valid_i during FLUSH SHALL be stalled (not dropped); input must be held by sender.
REQ-026 in_first_i and in_last_i both set on one part SHALL produce a single-slice write at in_vaddr_i.
REQ-027 in_first_i while cnt!=0 SHALL discard buffered partial parts (not written).
REQ-028 Data buffer contents need no reset; outputs only qualified by wr_valid_o, but be of unwritten slices SHALL always be 0.

Reset
REQ-029 On async_rst_ni low: state=FILL, cnt=0, addr=0, all byte enables=0; wr_valid_o=0, in_ready_o=1 immediately (asynchronously).
REQ-030 Reset during FLUSH SHALL abandon the pending write with no write accept; after release, first accepted part is treated as slice cnt=0.
REQ-031 Reset release SHALL be synchronous to clk_i in effect: no state change on the release edge other than normal operation.

Verification (PIPE_W=32, VREG_W=128)
REQ-032 Parts 0x11111111,0x22222222,0x33333333,0x44444444, masks 0xF, first on part0 vaddr=5, last on part3, wr_ready_i=1 -> one write addr=5, data=0x44444444_33333333_22222222_11111111, be=0xFFFF, cycle after part3; in_ready_o low one cycle.
REQ-033 8 parts, first vaddr=31, last on part7 -> writes to addr 31 then addr 0, each be=0xFFFF.
REQ-034 2 parts masks 0x3,0xF, last on part1, vaddr=2 -> addr 2, be=0x00F3, upper 64 bits don't-care.
REQ-035 wr_ready_i low 5 cycles during FLUSH with in_valid_i high -> outputs stable, in_ready_o=0, no part lost; next part lands in slice 0 after accept.
REQ-036 Single part first+last vaddr=7 mask 0x1 -> addr 7, be=0x0001; then assert async_rst_ni low mid-FLUSH -> wr_valid_o=0 same cycle, in_ready_o=1.
REQ-037 2 parts then new first (vaddr=9) -> earlier parts never written; write at addr 9 holds only new parts.
